serial_frame_receiver: RTL
==========================

// Module: serial_frame_receiver
// PURPOSE
//   Parametrised successor to the fixed 011010 + 32-bit serial receiver.
//   Hunts a configurable sync pattern on a 1-bit line with a sliding window,
//   then deserialises a PAYLOAD_LEN-bit payload MSB-first into OUT_WIDTH words.
//   Sits between the line front end and the packet buffer; one bit per clk.
// PARAMETERS
//   SYNC_LEN      6          sync pattern length in bits, >= 2
//   SYNC_PATTERN  6'b011010  sync pattern; MSB is the first bit on the line
//   PAYLOAD_LEN   32         payload bits per frame; must be a multiple of OUT_WIDTH
//   OUT_WIDTH     8          parallel word width, >= 1
// PORTS
//   clk        in   1          rising-edge clock; one serial bit per cycle
//   rst_n      in   1          asynchronous active-low reset
//   serData    in   1          serial input; sampled on every rising clk edge
//   outValid   out  1          high while the current serData bit is payload
//   wordData   out  OUT_WIDTH  last completed word; first payload bit in MSB
//   wordValid  out  1          1-cycle pulse: wordData holds a new word
//   frameDone  out  1          1-cycle pulse: frame complete
//   frameErr   out  1          qualified by frameDone; parity mismatch
// BEHAVIOUR
//   - Reset (async, any time): state=SEARCH, sync window=0, bit/word counters=0.
//     Outputs: outValid=0, wordData=0, wordValid=0, frameDone=0, frameErr=0.
//     A partial frame is discarded; no wordValid/frameDone is issued for it.
//   - States: SEARCH, DATA, PARITY (PARITY only with PARITY_EN).
//   - SEARCH: shift serData into a SYNC_LEN window each edge. A match of
//     {window[SYNC_LEN-2:0],serData}==SYNC_PATTERN moves to DATA at that edge.
//     Overlapping/partial prefixes recover: 0,1,1,0,1,1,0,1,0 syncs on bit 9.
//   - DATA: outValid = (state==DATA), Moore output. It is high for exactly
//     PAYLOAD_LEN cycles, aligned with the payload bits on the line. No sync
//     search in DATA: a payload containing SYNC_PATTERN is never re-synced.
//   - Deserialise: left-shift; every OUT_WIDTH-th payload bit loads wordData.
//     wordValid pulses in the cycle after the edge that sampled the word's last
//     bit (latency 1). PAYLOAD_LEN/OUT_WIDTH pulses per frame.
//   - The edge sampling the last payload bit leaves DATA. Next state is SEARCH,
//     or PARITY with PARITY_EN. The sync window is cleared at that point, so a
//     sync that starts on the very next bit is detected (back-to-back frames).
//   - Bit counter width $clog2(PAYLOAD_LEN)+1; wraps to 0 when DATA exits.
//   - Elaboration $error if PAYLOAD_LEN%OUT_WIDTH!=0, SYNC_LEN<2 or OUT_WIDTH<1.
// CONFIGURATION
//   PARITY_EN defined: one even-parity bit follows the payload (PARITY state).
//     outValid=0 during the parity bit; the last wordValid fires as normal.
//     frameDone pulses 1 cycle after the edge that samples the parity bit.
//     frameErr = XOR(payload bits, parity bit) in that same cycle.
//     After the parity bit the FSM returns to SEARCH with the window cleared.
//   PARITY_EN undefined: no PARITY state; frameErr tied 0.
//     frameDone pulses in the same cycle as the last wordValid.
// TESTING  (10 ns clk, defaults unless noted)
//   1. Reset, then 011010 + 32'hA5C30F96.
//      -> outValid high 32 cycles; wordValid x4: A5,C3,0F,96.
//      -> frameDone with 96; frameErr=0.
//   2. Bits 0,1,1,0,1,1,0,1,0 then a 32-bit payload.
//      -> sync on bit 9; outValid rises in the next cycle; frame OK.
//   3. Two frames back-to-back, no idle bits between them.
//      -> 8 wordValid pulses, 2 frameDone pulses; second sync not missed.
//   4. Sync + payload 32'h1A1A1A1A, followed by idle 1s.
//      -> exactly 4 words (1A x4), one frameDone, no re-sync inside payload.
//   5. Sync + 9 payload bits, then rst_n=0 for 20 ns.
//      -> outputs 0 asynchronously; only 1 wordValid was issued.
//      -> the next full frame is received normally.
//   6. PARITY_EN: sync + 32'hA5C30F96 + parity bit 1 (correct value is 0).
//      -> frameDone with frameErr=1.
//      -> repeat with parity bit 0 -> frameErr=0.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: hunts SYNC_PATTERN on a 1-bit line, then deserialises a PAYLOAD_LEN-bit
// payload MSB-first into OUT_WIDTH-bit words. Optional macro PARITY_EN adds a trailing even-parity bit.
module serial_frame_receiver #(
  parameter int                  SYNC_LEN     = 6,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 6'b011010,
  parameter int                  PAYLOAD_LEN  = 32,
  parameter int                  OUT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serData,
  output logic                 outValid,
  output logic [OUT_WIDTH-1:0] wordData,
  output logic                 wordValid,
  output logic                 frameDone,
  output logic                 frameErr
);

  localparam int CNT_W = $clog2(PAYLOAD_LEN) + 1;
  localparam int WB_W  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  if ((OUT_WIDTH < 1) || (SYNC_LEN < 2) ||
      ((PAYLOAD_LEN % ((OUT_WIDTH < 1) ? 1 : OUT_WIDTH)) != 0)) begin : g_param_chk
    $error("serial_frame_receiver: illegal SYNC_LEN/PAYLOAD_LEN/OUT_WIDTH combination");
  end

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
`ifdef PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DATA   = 2'd1
  } state_t;

  state_t               r_state;
  logic [SYNC_LEN-2:0]  r_win;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [WB_W-1:0]      r_wbit;
  logic [OUT_WIDTH-1:0] r_shift;
  logic [OUT_WIDTH-1:0] r_word;
  logic                 r_out_valid;
  logic                 r_word_valid;
  logic                 r_frame_done;
  logic                 r_frame_err;
`ifdef PARITY_EN
  logic                 r_par;
`endif

  logic [SYNC_LEN-1:0]  w_cand;
  logic                 w_sync_hit;
  logic [OUT_WIDTH-1:0] w_shift_next;

  // The window only keeps SYNC_LEN-1 history bits; the live bit completes the candidate.
  assign w_cand       = {r_win, serData};
  assign w_sync_hit   = (w_cand == SYNC_PATTERN);
  assign w_shift_next = (r_shift << 1) | OUT_WIDTH'(serData);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_SEARCH;
      r_win        <= '0;
      r_bit_cnt    <= '0;
      r_wbit       <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_out_valid  <= 1'b0;
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_SEARCH: begin
          r_win <= w_cand[SYNC_LEN-2:0];
          if (w_sync_hit) begin
            r_state     <= S_DATA;
            r_out_valid <= 1'b1;
          end else begin
            r_state     <= S_SEARCH;
          end
        end
        S_DATA: begin
          r_shift   <= w_shift_next;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`ifdef PARITY_EN
          r_par     <= r_par ^ serData;
`endif
          if (r_wbit == WB_W'(OUT_WIDTH - 1)) begin
            r_word       <= w_shift_next;
            r_word_valid <= 1'b1;
            r_wbit       <= '0;
          end else begin
            r_wbit       <= r_wbit + WB_W'(1);
          end
          // Clearing the window here lets a sync starting on the next bit be caught.
          if (r_bit_cnt == CNT_W'(PAYLOAD_LEN - 1)) begin
            r_bit_cnt   <= '0;
            r_win       <= '0;
            r_out_valid <= 1'b0;
`ifdef PARITY_EN
            r_state     <= S_PARITY;
`else
            r_state     <= S_SEARCH;
            r_frame_done <= 1'b1;
`endif
          end else begin
            r_state     <= S_DATA;
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          r_state      <= S_SEARCH;
          r_frame_done <= 1'b1;
          r_frame_err  <= r_par ^ serData;
          r_par        <= 1'b0;
          r_win        <= '0;
        end
`endif
        default: begin
          r_state     <= S_SEARCH;
          r_out_valid <= 1'b0;
          r_win       <= '0;
          r_bit_cnt   <= '0;
          r_wbit      <= '0;
        end
      endcase
    end
  end

  assign outValid  = r_out_valid;
  assign wordData  = r_word;
  assign wordValid = r_word_valid;
  assign frameDone = r_frame_done;
  assign frameErr  = r_frame_err;

endmodule
